// File: rtl/pipe_adder.sv
// Segmented carry-pipelined adder/subtractor.
// One SEG-bit carry segment per stage, valid/ready flow control with global stall.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG;

    if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
        $error("pipe_adder: WIDTH must be a positive multiple of SEG");
    end

    logic en;

    // Whole pipe advances together unless a result is waiting downstream.
    always_comb begin
        en = !out_valid | out_ready;
    end

    assign in_ready = en;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic             v_in;
        logic [SEG:0]     seg_sum;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] s_q;
        logic             carry_d;
        logic             carry_q;
        logic             valid_d;
        logic             valid_q;

        if (k == 0) begin : g_first
            // Subtract folds into add: invert b and force carry-in.
            assign a_in = a;
            assign b_in = mode ? ~b : b;
            assign c_in = mode | cin;
            assign s_in = '0;
            assign v_in = in_valid;
        end else begin : g_next
            assign a_in = g_stage[k-1].g_fwd.a_q;
            assign b_in = g_stage[k-1].g_fwd.b_q;
            assign c_in = g_stage[k-1].carry_q;
            assign s_in = g_stage[k-1].s_q;
            assign v_in = g_stage[k-1].valid_q;
        end

        // Add this stage's segment and splice it into the partial result.
        always_comb begin
            seg_sum = {1'b0, a_in[k*SEG +: SEG]}
                    + {1'b0, b_in[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_in};
            s_d = s_in;
            s_d[k*SEG +: SEG] = seg_sum[SEG-1:0];
            carry_d = seg_sum[SEG];
            valid_d = v_in;
        end

        // Stage result, carry and valid registers.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q     <= '0;
                carry_q <= 1'b0;
                valid_q <= 1'b0;
            end else if (en) begin
                s_q     <= s_d;
                carry_q <= carry_d;
                valid_q <= valid_d;
            end
        end

        if (k < NSEG - 1) begin : g_fwd
            logic [WIDTH-1:0] a_d;
            logic [WIDTH-1:0] b_d;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;

            // Operands ride along for the segments still to come.
            always_comb begin
                a_d = a_in;
                b_d = b_in;
            end

            // Operand delay registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == NSEG - 1) begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Signed overflow from effective operand signs vs result sign.
            always_comb begin
                ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1])
                     && (s_d[WIDTH-1] != a_in[WIDTH-1]);
            end

            // Overflow flag register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NSEG-1].valid_q;
    assign s         = g_stage[NSEG-1].s_q;
    assign cout      = g_stage[NSEG-1].carry_q;
    assign ovf       = g_stage[NSEG-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed cases, stall, reset, random.
// Expected results come from integer arithmetic on the operands.
module tb_pipe_adder;

    localparam int W    = 16;
    localparam int SEG  = 4;
    localparam int NSEG = W / SEG;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_done = 1'b0;

    pipe_adder #(.WIDTH(W), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ic, input logic im);
        longint ua, ub, r, sa, sb, sr;
        exp_t   e;
        ua = longint'(ia);
        ub = longint'(ib);
        sa = ia[W-1] ? ua - (longint'(1) << W) : ua;
        sb = ib[W-1] ? ub - (longint'(1) << W) : ub;
        if (im) begin
            r  = ua - ub + (longint'(1) << W);
            sr = sa - sb;
        end else begin
            r  = ua + ub + longint'(ic);
            sr = sa + sb + longint'(ic);
        end
        r   = r % (longint'(1) << (W + 1));
        e.s = W'(r);
        e.c = r[W];
        e.o = (sr > (longint'(1) << (W - 1)) - 1) || (sr < -(longint'(1) << (W - 1)));
        return e;
    endfunction

    // Monitor: pops on each output handshake, checks stall hold and in_ready.
    bit   stall_p = 1'b0;
    exp_t held;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_result", 64'({s, cout, ovf}), 64'(held));
            end
            chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got s=%h with empty queue", s);
                end else begin
                    chk("result", 64'({s, cout, ovf}), 64'(exp_q.pop_front()));
                end
            end
            stall_p = out_valid && !out_ready;
            held    = {s, cout, ovf};
        end
    end

    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic im, input exp_t e);
        int t;
        a        = ia;
        b        = ib;
        cin      = ic;
        mode     = im;
        in_valid = 1'b1;
        t        = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                return;
            end
            t++;
            if (t > 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_dir(input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ic, input logic im,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        e.s = es;
        e.c = ec;
        e.o = eo;
        send(ia, ib, ic, im, e);
    endtask

    task automatic send_rand();
        logic [W-1:0] ra, rb;
        logic         rc, rm;
        ra = W'($urandom);
        rb = W'($urandom);
        rc = 1'($urandom);
        rm = 1'($urandom);
        send(ra, rb, rc, rm, model(ra, rb, rc, rm));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("reset_hold_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;

        // Single add with latency check.
        send_dir(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (NSEG - 2) @(posedge clk);
        #1;
        chk("latency_early", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("latency_due", 64'(out_valid), 64'd1);
        idle(2);

        // Carry propagation and overflow corners.
        send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_dir(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_dir(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_dir(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        send_dir(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        send_dir(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_dir(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        idle(NSEG + 2);

        // Back-to-back stream with a three-cycle downstream stall.
        fork
            begin
                for (int i = 1; i <= 8; i++)
                    send_dir(W'(i), W'(i), 1'b0, 1'b0, W'(2 * i), 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(NSEG + 4);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Reset with three transactions in flight.
        send_rand();
        send_rand();
        send_rand();
        in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_dir(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        idle(NSEG + 2);
        chk("post_reset_drained", 64'(exp_q.size()), 64'd0);

        // Random traffic with random backpressure.
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(9) < 7);
                end
            end
        join_none
        for (int i = 0; i < 10000; i++) begin
            send_rand();
            if ($urandom_range(3) == 0) idle($urandom_range(2) + 1);
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("final_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits.
REQ-002 Parameter SEG, default 4: carry-segment width in bits; NSEG = WIDTH/SEG pipeline stages.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set on a/b/cin/mode is valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A (two's complement or unsigned).
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, used in add mode only.
REQ-010 mode  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result on s/cout/ovf is valid.
REQ-012 out_ready  input  1  downstream accepts result this cycle.
REQ-013 s  output  WIDTH  sum/difference.
REQ-014 cout  output  1  carry-out of MSB; in subtract mode 1 = no borrow.
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 Elaboration SHALL fail if WIDTH mod SEG != 0 or SEG < 1.
REQ-017 Add mode SHALL compute {cout,s} = a + b + cin, modulo 2^(WIDTH+1).
REQ-018 Subtract mode SHALL compute {cout,s} = a + ~b + 1; cin ignored.
REQ-019 ovf SHALL be 1 iff effective operand MSBs (a, b or ~b) are equal and s MSB differs from them.
REQ-020 Carry chain: stage k adds bits [k*SEG +: SEG] using the registered carry from stage k-1; stage 0 uses cin (add) or 1 (subtract).
REQ-021 Unprocessed upper operand segments and completed lower result segments SHALL be delayed alongside so that each transaction stays aligned.
REQ-022 Pipeline enable en = !out_valid | out_ready; all stage registers, valid bits included, advance only when en = 1.
REQ-023 in_ready SHALL equal en (combinational); a transfer occurs when in_valid & in_ready at a rising edge.
REQ-024 Latency: a transfer at edge n SHALL present its result with out_valid = 1 after edge n+NSEG-1, with no stall.
REQ-025 Throughput: one transfer per cycle while out_ready = 1; bubbles (in_valid = 0) SHALL propagate as valid = 0 slots.
REQ-026 While out_valid = 1 and out_ready = 0: s, cout, ovf, out_valid and all internal stages SHALL hold unchanged; in_ready = 0.
REQ-027 Simultaneous output drain and input accept in one cycle SHALL lose no transaction and duplicate none.
REQ-028 Results SHALL exit in acceptance order; capacity = NSEG transactions.
REQ-029 Full-length carry propagation (e.g. all-ones + 1) SHALL resolve correctly across all segments.
REQ-030 When out_valid = 0, s/cout/ovf values are don't-care and benches SHALL NOT check them.

Reset
REQ-031 rst_n low SHALL asynchronously clear all valid bits, carries, s, cout and ovf to 0; in_ready = 1 while rst_n is low or out_valid = 0.
REQ-032 Reset mid-operation SHALL discard all in-flight transactions; the first result after rst_n deasserts SHALL come from a post-reset transfer.
REQ-033 Reset deassertion SHALL take effect on the next rising edge with no extra idle cycles required.

Verification (WIDTH=16, SEG=4, NSEG=4)
REQ-034 Add a=0x1234, b=0x4321, cin=0 -> after 3 more edges s=0x5555, cout=0, ovf=0.
REQ-035 Add a=0xFFFF, b=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0; then a=0x7FFF, b=0x0000, cin=1 -> s=0x8000, cout=0, ovf=1.
REQ-036 Subtract a=0x0005, b=0x0003 -> s=0x0002, cout=1; then a=0x7FFF, b=0xFFFF -> s=0x8000, cout=0, ovf=1.
REQ-037 Stream 8 back-to-back adds (a=i, b=i, i=1..8) with out_ready low in cycles 5-7 -> in_ready low exactly while stalled, outputs 2,4,...,16 in order, none lost or duplicated.
REQ-038 Accept 3 transactions, assert rst_n=0 for 1 cycle mid-flight -> out_valid=0 immediately, no stale results emerge, and a new add 0x0001+0x0001 yields 0x0002.
REQ-039 Random 10k transactions, add and subtract mixed, random in_valid/out_ready -> scoreboard match on s, cout, ovf versus the reference model.
